// File: rtl/scs8hd_demux2i_pkg.sv
// Shared types and constants for the 1:2 inverting stream demultiplexer.
package scs8hd_demux2i_pkg;

    // Output channel identifier; the encoding matches the S select bit.
    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

    // Entries per channel buffer.
    localparam int unsigned DEMUX_DEPTH = 2;

    // Default widths for the data path and the transfer counters.
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

    // Channel buffer occupancy, 0..DEMUX_DEPTH.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = occ_t'(0);
    localparam occ_t OCC_ONE   = occ_t'(1);
    localparam occ_t OCC_FULL  = occ_t'(DEMUX_DEPTH);

    // Buffer can take no further word this cycle.
    function automatic logic occ_is_full(input occ_t occ);
        return occ == OCC_FULL;
    endfunction

    // Buffer holds at least one word.
    function automatic logic occ_is_valid(input occ_t occ);
        return occ != OCC_EMPTY;
    endfunction

endpackage

// File: rtl/scs8hd_demux2i_fifo2.sv
// Two-entry FIFO for one demux output channel. The head entry is the
// registered output word; the tail entry only fills when the head is busy.
module scs8hd_demux2i_fifo2
    import scs8hd_demux2i_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic [1:0]       occupancy
);

    occ_t             occ_q;
    occ_t             occ_nxt;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_nxt;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] tail_nxt;
    logic             do_push;
    logic             do_pop;

    assign valid     = occ_is_valid(occ_q);
    assign full      = occ_is_full(occ_q);
    assign occupancy = occ_q;
    assign dout      = head_q;

    // A full buffer never accepts, even when it pops in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    // Next occupancy and entry contents from the push/pop pair.
    always_comb begin
        occ_nxt  = occ_q;
        head_nxt = head_q;
        tail_nxt = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (do_push) begin
                    head_nxt = din;
                    occ_nxt  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                // Simultaneous push and pop: new word replaces the head.
                if (do_push && do_pop) begin
                    head_nxt = din;
                end else if (do_push) begin
                    tail_nxt = din;
                    occ_nxt  = OCC_FULL;
                end else if (do_pop) begin
                    occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (do_pop) begin
                    head_nxt = tail_q;
                    occ_nxt  = OCC_ONE;
                end
            end
            default: begin
                occ_nxt = OCC_EMPTY;
            end
        endcase
    end

    // Buffer state registers; head resets to all-ones so the idle output is known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '1;
            tail_q <= '1;
        end else begin
            occ_q  <= occ_nxt;
            head_q <= head_nxt;
            tail_q <= tail_nxt;
        end
    end

endmodule

// File: rtl/scs8hd_demux2i_stream.sv
// Clocked 1:2 inverting stream demultiplexer: each accepted word is inverted
// and buffered for the channel chosen by S; each channel drains on its own
// valid/ready and keeps a saturating count of words delivered.
module scs8hd_demux2i_stream
    import scs8hd_demux2i_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic [WIDTH-1:0] A,
    input  logic             S,
    input  logic             A_VALID,
    output logic             A_READY,
    output logic [WIDTH-1:0] Y0,
    output logic             Y0_VALID,
    input  logic             Y0_READY,
    output logic [CNT_W-1:0] Y0_CNT,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_VALID,
    input  logic             Y1_READY,
    output logic [CNT_W-1:0] Y1_CNT,
    input  logic             CLR_CNT
);

    chan_e            sel;
    logic [WIDTH-1:0] din_inv;
    logic             accept;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;
    logic             full0;
    logic             full1;
    logic [1:0]       occ0;
    logic [1:0]       occ1;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    assign sel     = chan_e'(S);
    assign din_inv = ~A;
    assign accept  = A_VALID & A_READY;
    assign push0   = accept & (sel == CH0);
    assign push1   = accept & (sel == CH1);
    assign pop0    = Y0_VALID & Y0_READY;
    assign pop1    = Y1_VALID & Y1_READY;

    // Input ready follows only the selected channel's occupancy, never a consumer ready.
    always_comb begin
        A_READY = 1'b0;
        case (sel)
            CH0:     A_READY = ~full0;
            CH1:     A_READY = ~full1;
            default: A_READY = 1'b0;
        endcase
    end

    scs8hd_demux2i_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo0 (
        .clk      (CLK),
        .rst_n    (RESETB),
        .push     (push0),
        .pop      (pop0),
        .din      (din_inv),
        .dout     (Y0),
        .valid    (Y0_VALID),
        .full     (full0),
        .occupancy(occ0)
    );

    scs8hd_demux2i_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo1 (
        .clk      (CLK),
        .rst_n    (RESETB),
        .push     (push1),
        .pop      (pop1),
        .din      (din_inv),
        .dout     (Y1),
        .valid    (Y1_VALID),
        .full     (full1),
        .occupancy(occ1)
    );

    // Channel 0 delivered-word counter; clear wins over increment, saturates at all-ones.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            cnt0_q <= '0;
        end else if (CLR_CNT) begin
            cnt0_q <= '0;
        end else if (pop0 && (cnt0_q != '1)) begin
            cnt0_q <= cnt0_q + CNT_W'(1);
        end
    end

    // Channel 1 delivered-word counter; clear wins over increment, saturates at all-ones.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            cnt1_q <= '0;
        end else if (CLR_CNT) begin
            cnt1_q <= '0;
        end else if (pop1 && (cnt1_q != '1)) begin
            cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign Y0_CNT = cnt0_q;
    assign Y1_CNT = cnt1_q;

    // Buffers never hold more than their depth.
    occ0_bound: assert property (@(posedge CLK) disable iff (!RESETB)
        occ_t'(occ0) <= OCC_FULL);
    occ1_bound: assert property (@(posedge CLK) disable iff (!RESETB)
        occ_t'(occ1) <= OCC_FULL);

endmodule
